// File: rtl/busmatrix_pkg.sv
// Shared types and constants for the AHB bus matrix output-stage arbiter.
// Holds the HTRANS encodings, the arbiter state enum and the default sizing.
package busmatrix_pkg;

    localparam int NUM_PORTS_DEF = 5;
    localparam int PORT_W_DEF    = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_NOPORT  = 2'd0,
        ST_GRANTED = 2'd1,
        ST_HOLD    = 2'd2
    } arb_state_e;

    // A beat that moves data (NONSEQ or SEQ).
    function automatic logic is_data_beat(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    // A beat that continues an open burst (BUSY or SEQ).
    function automatic logic is_burst_cont(input logic [1:0] htrans);
        return (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/busmatrix_rr_pick.sv
// Rotate-priority picker: first set request at or after start, wrapping
// from NUM_PORTS-1 back to 0.
module busmatrix_rr_pick
    import busmatrix_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = PORT_W_DEF
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    start,
    output logic [PORT_W-1:0]    winner,
    output logic                 any_req
);

    always_comb begin
        logic            found;
        int              idx;
        logic [PORT_W-1:0] idx_w;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_w  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            idx_w = PORT_W'(idx);
            if (!found && req[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
        any_req = |req;
    end

endmodule

// File: rtl/busmatrix_out_arbiter.sv
// Round-robin arbiter for one output stage of the AHB bus matrix: address-phase
// grant with lock/burst hold, plus the data-phase owner for response routing.
module busmatrix_out_arbiter
    import busmatrix_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = PORT_W_DEF
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HREADYM,
    input  logic [NUM_PORTS-1:0] req_in,
    input  logic [1:0]           HTRANSM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic [NUM_PORTS-1:0] active_out,
    output logic [PORT_W-1:0]    data_in_port,
    output logic                 data_valid
);

    arb_state_e        state_q, state_d;
    logic [PORT_W-1:0] addr_port_q, addr_port_d;
    logic              no_port_q, no_port_d;
    logic [PORT_W-1:0] last_grant_q, last_grant_d;
    logic [PORT_W-1:0] data_port_q, data_port_d;
    logic              data_valid_q, data_valid_d;

    logic [PORT_W-1:0] rr_start;
    logic [PORT_W-1:0] rr_winner;
    logic              rr_any;
    logic              owner_req;
    logic              hold_cond;
    logic              do_grant;
    logic              do_release;

    assign rr_start = (last_grant_q == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                : last_grant_q + PORT_W'(1);

    busmatrix_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_rr_pick (
        .req     (req_in),
        .start   (rr_start),
        .winner  (rr_winner),
        .any_req (rr_any)
    );

    assign owner_req = req_in[addr_port_q];
    // An owner that stops requesting has abandoned its burst, so SEQ/BUSY alone
    // no longer pins the grant.
    assign hold_cond = HMASTLOCKM | (is_burst_cont(HTRANSM) & owner_req);

    always_comb begin
        state_d      = state_q;
        addr_port_d  = addr_port_q;
        no_port_d    = no_port_q;
        last_grant_d = last_grant_q;
        data_port_d  = data_port_q;
        data_valid_d = data_valid_q;
        do_grant     = 1'b0;
        do_release   = 1'b0;

        if (HREADYM) begin
            data_port_d  = addr_port_q;
            data_valid_d = ~no_port_q & is_data_beat(HTRANSM);

            case (state_q)
                ST_NOPORT: begin
                    do_grant = rr_any;
                end
                ST_GRANTED: begin
                    if (hold_cond) begin
                        state_d = ST_HOLD;
                    end else if (rr_any) begin
                        do_grant = 1'b1;
                    end else begin
                        do_release = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!hold_cond) begin
                        do_grant   = rr_any;
                        do_release = ~rr_any;
                    end
                end
                default: begin
                    do_release = 1'b1;
                end
            endcase

            if (do_grant) begin
                state_d      = ST_GRANTED;
                addr_port_d  = rr_winner;
                last_grant_d = rr_winner;
                no_port_d    = 1'b0;
            end else if (do_release) begin
                state_d   = ST_NOPORT;
                no_port_d = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= ST_NOPORT;
            addr_port_q  <= '0;
            no_port_q    <= 1'b1;
            last_grant_q <= PORT_W'(NUM_PORTS - 1);
            data_port_q  <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_port_q  <= addr_port_d;
            no_port_q    <= no_port_d;
            last_grant_q <= last_grant_d;
            data_port_q  <= data_port_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        active_out = '0;
        if (!no_port_q) begin
            active_out[addr_port_q] = 1'b1;
        end
    end

    assign addr_in_port = addr_port_q;
    assign no_port      = no_port_q;
    assign data_in_port = data_port_q;
    assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_busmatrix_out_arbiter.sv
// Directed-vector bench for busmatrix_out_arbiter with hand-computed expectations.
module tb_busmatrix_out_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic       HCLK;
    logic       HRESET;
    logic       HREADYM;
    logic [4:0] req_in;
    logic [1:0] HTRANSM;
    logic       HMASTLOCKM;
    logic [2:0] addr_in_port;
    logic       no_port;
    logic [4:0] active_out;
    logic [2:0] data_in_port;
    logic       data_valid;

    int errors;
    int checks;

    busmatrix_out_arbiter dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HREADYM      (HREADYM),
        .req_in       (req_in),
        .HTRANSM      (HTRANSM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .active_out   (active_out),
        .data_in_port (data_in_port),
        .data_valid   (data_valid)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        HRESET     = 1'b1;
        req_in     = 5'b00000;
        HTRANSM    = T_IDLE;
        HMASTLOCKM = 1'b0;
        HREADYM    = 1'b1;
        tick();
        HRESET = 1'b0;
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] prev_addr;

    initial begin
        errors = 0;
        checks = 0;
        rr_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};

        // reset state
        do_reset();
        HRESET = 1'b1;
        tick();
        check("rst_addr", 32'(addr_in_port), 32'd0);
        check("rst_noport", 32'(no_port), 32'd1);
        check("rst_active", 32'(active_out), 32'd0);
        check("rst_dport", 32'(data_in_port), 32'd0);
        check("rst_dvalid", 32'(data_valid), 32'd0);
        HRESET = 1'b0;

        // single request from port 2
        req_in  = 5'b00100;
        HTRANSM = T_NONSEQ;
        tick();
        check("p2_addr", 32'(addr_in_port), 32'd2);
        check("p2_active", 32'(active_out), 32'h04);
        check("p2_noport", 32'(no_port), 32'd0);
        check("p2_dvalid_early", 32'(data_valid), 32'd0);
        tick();
        check("p2_dport", 32'(data_in_port), 32'd2);
        check("p2_dvalid", 32'(data_valid), 32'd1);
        req_in  = 5'b00000;
        HTRANSM = T_IDLE;
        tick();
        check("idle_noport", 32'(no_port), 32'd1);
        check("idle_active", 32'(active_out), 32'd0);

        // all ports requesting: 0,1,2,3,4,0
        do_reset();
        req_in    = 5'b11111;
        HTRANSM   = T_NONSEQ;
        prev_addr = 3'd0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("rr_addr%0d", k), 32'(addr_in_port), 32'(rr_exp[k]));
            check($sformatf("rr_active%0d", k), 32'(active_out), 32'(5'b00001 << rr_exp[k]));
            if (k > 0) begin
                check($sformatf("rr_dport%0d", k), 32'(data_in_port), 32'(prev_addr));
            end
            prev_addr = rr_exp[k];
        end

        // 4-beat burst from port 1, port 3 joins on the SEQ beats
        do_reset();
        req_in  = 5'b00010;
        HTRANSM = T_IDLE;
        tick();
        check("bu_grant", 32'(addr_in_port), 32'd1);
        HTRANSM = T_NONSEQ;
        tick();
        check("bu_beat1", 32'(addr_in_port), 32'd1);
        req_in  = 5'b01010;
        HTRANSM = T_SEQ;
        for (int b = 2; b <= 4; b++) begin
            tick();
            check($sformatf("bu_beat%0d", b), 32'(addr_in_port), 32'd1);
        end
        check("bu_dvalid", 32'(data_valid), 32'd1);
        req_in  = 5'b01000;
        HTRANSM = T_IDLE;
        tick();
        check("bu_p3_grant", 32'(addr_in_port), 32'd3);
        check("bu_p3_dport", 32'(data_in_port), 32'd1);

        // port 1 abandons burst after beat 2
        do_reset();
        req_in  = 5'b00010;
        HTRANSM = T_IDLE;
        tick();
        HTRANSM = T_NONSEQ;
        tick();
        req_in  = 5'b01010;
        HTRANSM = T_SEQ;
        tick();
        check("ab_hold", 32'(addr_in_port), 32'd1);
        req_in = 5'b01000;
        tick();
        check("ab_p3_grant", 32'(addr_in_port), 32'd3);

        // locked port 0 with wait states, port 4 waiting
        do_reset();
        req_in = 5'b00001;
        tick();
        check("lk_grant", 32'(addr_in_port), 32'd0);
        req_in     = 5'b10001;
        HMASTLOCKM = 1'b1;
        HTRANSM    = T_NONSEQ;
        tick();
        check("lk_held", 32'(addr_in_port), 32'd0);
        check("lk_dvalid", 32'(data_valid), 32'd1);
        HTRANSM = T_IDLE;
        HREADYM = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            check($sformatf("lk_wait_addr%0d", w), 32'(addr_in_port), 32'd0);
            check($sformatf("lk_wait_dport%0d", w), 32'(data_in_port), 32'd0);
            check($sformatf("lk_wait_dvalid%0d", w), 32'(data_valid), 32'd1);
        end
        HREADYM = 1'b1;
        tick();
        check("lk_still", 32'(addr_in_port), 32'd0);
        check("lk_dvalid_idle", 32'(data_valid), 32'd0);
        HMASTLOCKM = 1'b0;
        tick();
        check("lk_p4_grant", 32'(addr_in_port), 32'd4);
        check("lk_p4_active", 32'(active_out), 32'h10);

        // reset during HOLD
        do_reset();
        req_in  = 5'b00010;
        tick();
        HTRANSM = T_NONSEQ;
        tick();
        req_in  = 5'b01010;
        HTRANSM = T_SEQ;
        tick();
        HMASTLOCKM = 1'b1;
        HRESET     = 1'b1;
        tick();
        check("rh_addr", 32'(addr_in_port), 32'd0);
        check("rh_noport", 32'(no_port), 32'd1);
        check("rh_active", 32'(active_out), 32'd0);
        check("rh_dvalid", 32'(data_valid), 32'd0);
        HRESET     = 1'b0;
        HMASTLOCKM = 1'b0;
        HTRANSM    = T_IDLE;
        tick();
        check("rh_first_grant", 32'(addr_in_port), 32'd1);
        check("rh_first_noport", 32'(no_port), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
